// File: rtl/wb_byte_master.sv
// Byte-stream to Wishbone single-cycle initiator with bus timeout and read-response stream.
// Build option WB_BYTE_MASTER_AUTOINC_EN adds write-next/read-next opcodes and address auto-increment.
module wb_byte_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] wb_addr,
    output logic [31:0] wb_wdata,
    input  logic [31:0] wb_rdata,
    output logic        wb_cyc,
    output logic        wb_we,
    input  logic        wb_ack,
    output logic        err_timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_HI = 3'd1;
    localparam logic [2:0] S_ADDR_LO = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_BUS     = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [7:0] OP_WR  = 8'h01;
    localparam logic [7:0] OP_RD  = 8'h02;
`ifdef WB_BYTE_MASTER_AUTOINC_EN
    localparam logic [7:0] OP_WRN = 8'h11;
    localparam logic [7:0] OP_RDN = 8'h12;
`endif

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    logic [2:0]  r_state;
    logic        r_is_write;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_addr;
    logic [23:0] r_wbuf;
    logic [31:0] r_shift;
    logic [15:0] r_to_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_wb_cyc;
    logic        r_wb_we;
    logic [15:0] r_wb_addr;
    logic [31:0] r_wb_wdata;
    logic        r_err_timeout;

    logic [2:0]  w_state_nxt;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_to_hit;
    logic        w_bus_start;
    logic        w_bus_we;
    logic [15:0] w_bus_addr;
    logic        w_op_is_write;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_to_hit   = ((r_to_cnt + 16'd1) == TO_LIM);

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_shift[31:24];
    assign wb_cyc      = r_wb_cyc;
    assign wb_we       = r_wb_we;
    assign wb_addr     = r_wb_addr;
    assign wb_wdata    = r_wb_wdata;
    assign err_timeout = r_err_timeout;

    // Frame sequencing: next state from the accepted byte, bus completion or response drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    case (in_data)
                        OP_WR, OP_RD: w_state_nxt = S_ADDR_HI;
`ifdef WB_BYTE_MASTER_AUTOINC_EN
                        OP_WRN:       w_state_nxt = S_DATA;
                        OP_RDN:       w_state_nxt = S_BUS;
`endif
                        default:      w_state_nxt = S_IDLE;
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR_HI: begin
                if (w_in_fire) begin
                    w_state_nxt = S_ADDR_LO;
                end else begin
                    w_state_nxt = S_ADDR_HI;
                end
            end
            S_ADDR_LO: begin
                if (w_in_fire) begin
                    w_state_nxt = r_is_write ? S_DATA : S_BUS;
                end else begin
                    w_state_nxt = S_ADDR_LO;
                end
            end
            S_DATA: begin
                if (w_in_fire && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = S_BUS;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_BUS: begin
                if (wb_ack || w_to_hit) begin
                    w_state_nxt = r_is_write ? S_IDLE : S_RESP;
                end else begin
                    w_state_nxt = S_BUS;
                end
            end
            S_RESP: begin
                if (w_out_fire && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus-cycle launch parameters; only a read-next launches straight from IDLE
    always_comb begin
        w_bus_start   = (w_state_nxt == S_BUS) && (r_state != S_BUS);
        w_bus_we      = (r_state == S_IDLE) ? 1'b0 : r_is_write;
`ifdef WB_BYTE_MASTER_AUTOINC_EN
        w_op_is_write = (in_data == OP_WR) || (in_data == OP_WRN);
`else
        w_op_is_write = (in_data == OP_WR);
`endif
        if (r_state == S_ADDR_LO) begin
            w_bus_addr = {r_addr[15:8], in_data};
        end else begin
            w_bus_addr = r_addr;
        end
    end

    // State, frame capture, Wishbone cycle, timeout and response shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_is_write    <= 1'b0;
            r_byte_cnt    <= 2'd0;
            r_addr        <= 16'd0;
            r_wbuf        <= 24'd0;
            r_shift       <= 32'd0;
            r_to_cnt      <= 16'd0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_wb_cyc      <= 1'b0;
            r_wb_we       <= 1'b0;
            r_wb_addr     <= 16'd0;
            r_wb_wdata    <= 32'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_in_ready    <= (w_state_nxt != S_BUS) && (w_state_nxt != S_RESP);
            r_err_timeout <= 1'b0;

            // The last frame byte is still on in_data when the cycle launches
            if (w_bus_start) begin
                r_wb_cyc  <= 1'b1;
                r_wb_we   <= w_bus_we;
                r_wb_addr <= w_bus_addr;
                r_to_cnt  <= 16'd0;
                if (w_bus_we) begin
                    r_wb_wdata <= {r_wbuf, in_data};
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_byte_cnt <= 2'd0;
                        r_is_write <= w_op_is_write;
                    end
                end
                S_ADDR_HI: begin
                    if (w_in_fire) begin
                        r_addr[15:8] <= in_data;
                    end
                end
                S_ADDR_LO: begin
                    if (w_in_fire) begin
                        r_addr[7:0] <= in_data;
                    end
                end
                S_DATA: begin
                    if (w_in_fire) begin
                        r_wbuf     <= {r_wbuf[15:0], in_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_BUS: begin
                    // An ack on the timeout edge still counts as success
                    if (wb_ack || w_to_hit) begin
                        r_wb_cyc      <= 1'b0;
                        r_wb_we       <= 1'b0;
                        r_byte_cnt    <= 2'd0;
                        r_err_timeout <= ~wb_ack;
                        if (!r_is_write) begin
                            r_shift     <= wb_ack ? wb_rdata : 32'hFFFF_FFFF;
                            r_out_valid <= 1'b1;
                        end
`ifdef WB_BYTE_MASTER_AUTOINC_EN
                        r_addr <= r_addr + 16'd1;
`endif
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (w_out_fire) begin
                        r_shift    <= {r_shift[23:0], 8'd0};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_byte_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_byte_master.sv
// Self-checking bench for wb_byte_master: directed vector table, reset/option sequences,
// and randomized frames checked against a frame-level reference model.
module tb_wb_byte_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_cyc;
    logic        wb_we;
    logic        wb_ack;
    logic        err_timeout;

    wb_byte_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_cyc(wb_cyc), .wb_we(wb_we), .wb_ack(wb_ack),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Slave: acks after s_delay extra cycles of wb_cyc, or never when s_noack
    int s_cnt   = 0;
    int s_delay = 0;
    bit s_noack = 1'b0;
    always @(posedge clk) s_cnt <= wb_cyc ? s_cnt + 1 : 0;
    assign wb_ack = wb_cyc && !s_noack && (s_cnt == s_delay);

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } txn_t;

    txn_t txq[$];
    txn_t m_cur;
    bit   m_prev = 1'b0;
    bit   mon_en = 1'b0;
    int   m_unstable = 0;
    int   m_rdy_bad = 0;
    int   m_we_idle_bad = 0;
    int   m_to_pulses = 0;

    // Bus monitor: records each completed cycle and protocol violations
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_cyc) begin
                if (!m_prev) begin
                    m_cur.addr  = wb_addr;
                    m_cur.we    = wb_we;
                    m_cur.wdata = wb_wdata;
                    m_cur.len   = 1;
                end else begin
                    m_cur.len++;
                    if (wb_addr !== m_cur.addr || wb_we !== m_cur.we || wb_wdata !== m_cur.wdata)
                        m_unstable++;
                end
                if (in_ready) m_rdy_bad++;
            end else begin
                if (m_prev) txq.push_back(m_cur);
                if (wb_we) m_we_idle_bad++;
            end
            if (err_timeout) m_to_pulses++;
            m_prev = wb_cyc;
        end else begin
            m_prev = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic [79:0] bytes;
        int          nb;
        int          dly;
        bit          noack;
        logic [31:0] rdata;
        bit          has_txn;
        logic [15:0] a;
        bit          we;
        logic [31:0] wd;
        int          len;
        bit          has_resp;
        logic [31:0] resp;
        int          to;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 1'b0;
        repeat (gap) tick;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_frame(input bq_t q, input bit rnd);
        foreach (q[k]) send_byte(q[k], rnd ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic expect_txn(input string tag, input logic [15:0] a, input logic we,
                              input logic [31:0] wd, input int len);
        for (int k = 0; k < 100 && txq.size() == 0; k++) tick;
        if (txq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_cycle: got no bus cycle, expected one", tag);
        end else begin
            txn_t t;
            t = txq.pop_front();
            check({tag, "_addr"}, 32'(t.addr), 32'(a));
            check({tag, "_we"}, 32'(t.we), 32'(we));
            if (we) check({tag, "_wdata"}, t.wdata, wd);
            check({tag, "_len"}, 32'(t.len), 32'(len));
        end
    endtask

    task automatic recv_resp(input string tag, input bit rnd, output logic [31:0] got);
        int          cnt = 0;
        bit          held = 1'b0;
        logic [7:0]  hd = 8'd0;
        got = 32'd0;
        for (int c = 0; c < 300 && cnt < 4; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : (c % 2 == 1);
            @(negedge clk);
            if (held) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_data"}, 32'(out_data), 32'(hd));
            end
            if (out_valid && out_ready) begin
                got  = {got[23:0], out_data};
                cnt++;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                hd   = out_data;
            end else begin
                held = 1'b0;
            end
            tick;
        end
        out_ready = 1'b0;
        check({tag, "_count"}, 32'(cnt), 32'd4);
        @(negedge clk);
        check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
        tick;
    endtask

    initial begin
        bq_t         fr;
        logic [31:0] got;
        int          p0;
        int          exp_to_total = 0;
        logic [15:0] m_addr = 16'd0;

        vt[0] = '{80'h01000100040404000000, 7, 1, 1'b0, 32'h0, 1'b1, 16'h0001, 1'b1, 32'h00040404, 2, 1'b0, 32'h0, 0};
        vt[1] = '{80'h02000000000000000000, 3, 3, 1'b0, 32'h12345678, 1'b1, 16'h0000, 1'b0, 32'h0, 4, 1'b1, 32'h12345678, 0};
        vt[2] = '{80'h02000300000000000000, 3, 0, 1'b1, 32'h5A5A5A5A, 1'b1, 16'h0003, 1'b0, 32'h0, 8, 1'b1, 32'hFFFFFFFF, 1};
        vt[3] = '{80'h7F00011234ABCDEF0100, 9, 0, 1'b0, 32'h0, 1'b1, 16'h1234, 1'b1, 32'hABCDEF01, 1, 1'b0, 32'h0, 0};
        vt[4] = '{80'h01BEEF11223344000000, 7, 0, 1'b1, 32'h0, 1'b1, 16'hBEEF, 1'b1, 32'h11223344, 8, 1'b0, 32'h0, 1};
        vt[5] = '{80'h02807F00000000000000, 3, 7, 1'b0, 32'hCAFEF00D, 1'b1, 16'h807F, 1'b0, 32'h0, 8, 1'b1, 32'hCAFEF00D, 0};
        vt[6] = '{80'h55000000000000000000, 1, 0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 0};

        rst       = 1'b1;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wb_rdata  = 32'd0;
        repeat (3) tick;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        tick;
        mon_en = 1'b1;

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            s_delay  = vt[v].dly;
            s_noack  = vt[v].noack;
            wb_rdata = vt[v].rdata;
            p0       = m_to_pulses;
            fr.delete();
            for (int k = 0; k < vt[v].nb; k++) fr.push_back(vt[v].bytes[79 - 8 * k -: 8]);
            send_frame(fr, 1'b0);
            if (vt[v].has_txn) begin
                expect_txn($sformatf("vec%0d", v), vt[v].a, vt[v].we, vt[v].wd, vt[v].len);
            end else begin
                repeat (4) tick;
                check($sformatf("vec%0d_no_cycle", v), 32'(txq.size()), 32'd0);
            end
            if (vt[v].has_resp) begin
                recv_resp($sformatf("vec%0d_resp", v), 1'b0, got);
                check($sformatf("vec%0d_resp_data", v), got, vt[v].resp);
            end
            repeat (2) tick;
            check($sformatf("vec%0d_timeouts", v), 32'(m_to_pulses - p0), 32'(vt[v].to));
            exp_to_total += vt[v].to;
        end

        // Reset while a read cycle is waiting for ack
        s_noack = 1'b1;
        fr.delete();
        fr.push_back(8'h02); fr.push_back(8'h00); fr.push_back(8'h05);
        send_frame(fr, 1'b0);
        @(negedge clk);
        check("midrst_cyc_before", 32'(wb_cyc), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        check("midrst_cyc", 32'(wb_cyc), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick;
        @(negedge clk);
        check("midrst_in_ready2", 32'(in_ready), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        @(negedge clk);
        check("midrst_rel_ready", 32'(in_ready), 32'd1);
        tick;
        txq.delete();
        s_noack = 1'b0;
        s_delay = 2;
        fr.delete();
        fr.push_back(8'h01); fr.push_back(8'h00); fr.push_back(8'h42);
        fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);
        send_frame(fr, 1'b0);
        expect_txn("postrst", 16'h0042, 1'b1, 32'hDEADBEEF, 3);

`ifdef WB_BYTE_MASTER_AUTOINC_EN
        s_delay = 0;
        fr.delete();
        fr.push_back(8'h01); fr.push_back(8'hFF); fr.push_back(8'hFF);
        fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'hAA);
        send_frame(fr, 1'b0);
        expect_txn("ainc_w0", 16'hFFFF, 1'b1, 32'h000000AA, 1);
        fr.delete();
        fr.push_back(8'h11); fr.push_back(8'h00); fr.push_back(8'h00);
        fr.push_back(8'h00); fr.push_back(8'hBB);
        send_frame(fr, 1'b0);
        expect_txn("ainc_w1", 16'h0000, 1'b1, 32'h000000BB, 1);
        wb_rdata = 32'h01020304;
        fr.delete();
        fr.push_back(8'h12);
        send_frame(fr, 1'b0);
        expect_txn("ainc_r", 16'h0001, 1'b0, 32'h0, 1);
        recv_resp("ainc_resp", 1'b0, got);
        check("ainc_resp_data", got, 32'h01020304);
`else
        s_delay = 0;
        fr.delete();
        fr.push_back(8'h11); fr.push_back(8'h12);
        fr.push_back(8'h01); fr.push_back(8'h00); fr.push_back(8'h10);
        fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h77);
        send_frame(fr, 1'b0);
        expect_txn("noainc", 16'h0010, 1'b1, 32'h00000077, 1);
        repeat (3) tick;
        check("noainc_extra", 32'(txq.size()), 32'd0);
`endif

        // Randomized frames against the frame-level reference model
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [15:0] ra;
            logic [31:0] rd;
            logic [31:0] rr;
            bit          rna;
            int          rdl;
`ifdef WB_BYTE_MASTER_AUTOINC_EN
            kind = (i == 0) ? 0 : int'($urandom_range(0, 11));
`else
            kind = (i == 0) ? 0 : int'($urandom_range(0, 9));
`endif
            ra  = 16'($urandom);
            rd  = $urandom;
            rr  = $urandom;
            rna = ($urandom_range(0, 7) == 0);
            rdl = int'($urandom_range(0, 7));
            s_noack  = rna;
            s_delay  = rdl;
            wb_rdata = rr;
            fr.delete();
            if (kind <= 3 || kind == 10) begin
                if (kind == 10) begin
                    fr.push_back(8'h11);
                end else begin
                    fr.push_back(8'h01); fr.push_back(ra[15:8]); fr.push_back(ra[7:0]);
                    m_addr = ra;
                end
                fr.push_back(rd[31:24]); fr.push_back(rd[23:16]);
                fr.push_back(rd[15:8]);  fr.push_back(rd[7:0]);
                send_frame(fr, 1'b1);
                expect_txn($sformatf("rnd%0d_w", i), m_addr, 1'b1, rd, rna ? TO : rdl + 1);
            end else if (kind <= 7 || kind == 11) begin
                if (kind == 11) begin
                    fr.push_back(8'h12);
                end else begin
                    fr.push_back(8'h02); fr.push_back(ra[15:8]); fr.push_back(ra[7:0]);
                    m_addr = ra;
                end
                send_frame(fr, 1'b1);
                expect_txn($sformatf("rnd%0d_r", i), m_addr, 1'b0, 32'h0, rna ? TO : rdl + 1);
                recv_resp($sformatf("rnd%0d_resp", i), 1'b1, got);
                check($sformatf("rnd%0d_resp_data", i), got, rna ? 32'hFFFFFFFF : rr);
            end else begin
                logic [7:0] jb;
                for (int j = 0; j < 2; j++) begin
                    jb = 8'($urandom);
                    while (jb == 8'h01 || jb == 8'h02 || jb == 8'h11 || jb == 8'h12) jb = 8'($urandom);
                    fr.push_back(jb);
                end
                send_frame(fr, 1'b1);
                repeat (3) tick;
                check($sformatf("rnd%0d_junk", i), 32'(txq.size()), 32'd0);
                rna = 1'b0;
            end
            if (kind <= 7 || kind >= 10) begin
                if (rna) exp_to_total++;
`ifdef WB_BYTE_MASTER_AUTOINC_EN
                m_addr = m_addr + 16'd1;
`endif
            end
        end

        repeat (3) tick;
        check("total_timeouts", 32'(m_to_pulses), 32'(exp_to_total));
        check("addr_we_stable", 32'(m_unstable), 32'd0);
        check("in_ready_in_cyc", 32'(m_rdy_bad), 32'd0);
        check("we_outside_cyc", 32'(m_we_idle_bad), 32'd0);
        check("no_stray_cycles", 32'(txq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
Byte-stream to Wishbone initiator, the bus-master counterpart of the register slaves in the spi-to-rgb design (e.g. the RGB effects block).
- Consumes framed command bytes from the SPI front end on a valid/ready stream.
- Issues single Wishbone write or read cycles.
- Returns read data as a byte stream.

Parameters:
TIMEOUT_CYCLES, 255, max clocks wb_cyc stays high waiting for wb_ack before abort (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
in_data  in  8  command stream byte
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle (transfer = in_valid & in_ready)
out_data  out  8  read-response byte
out_valid  out  1  out_data valid, held until accepted
out_ready  in  1  sink accepts out_data
wb_addr  out  16  Wishbone address
wb_wdata  out  32  Wishbone write data
wb_rdata  in  32  Wishbone read data
wb_cyc  out  1  Wishbone cycle/strobe
wb_we  out  1  Wishbone write enable
wb_ack  in  1  Wishbone acknowledge
err_timeout  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset (sync, active-high, wins over everything): all outputs 0, state IDLE, counters 0. Reset mid-cycle drops wb_cyc at that edge; partial frames are discarded.
- Frame format, all multi-byte fields MSB first:
  - Write: 0x01, addr[15:8], addr[7:0], d[31:24], d[23:16], d[15:8], d[7:0].
  - Read: 0x02, addr[15:8], addr[7:0].
  - Any other opcode byte is consumed and ignored; state stays IDLE.
- States:
  - IDLE → ADDR_HI on valid opcode.
  - ADDR_HI → ADDR_LO.
  - ADDR_LO → DATA (write) or BUS (read).
  - DATA: 4 bytes via 2-bit counter → BUS.
  - BUS → RESP (read) or IDLE (write).
  - RESP: 4 bytes → IDLE.
- in_ready = 1 only in IDLE, ADDR_HI, ADDR_LO, DATA; 0 in BUS and RESP. in_ready is registered-state-derived, never combinational from in_valid.
- Bus cycle:
  - wb_cyc rises on the clock edge that accepts the last frame byte. wb_addr, wb_wdata and wb_we are valid and stable that same cycle and throughout the cycle.
  - wb_ack is sampled at posedge. On the edge where wb_ack=1 is seen, wb_cyc goes 0; for reads, wb_rdata is captured into a 32-bit shift register.
  - Minimum cycle length is 1 clock (ack in the first wb_cyc cycle).
  - After wb_cyc falls, wb_we returns to 0. wb_addr and wb_wdata hold their last values.
- Timeout:
  - A 16-bit counter clears on wb_cyc rise and increments each wb_cyc cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: drop wb_cyc, pulse err_timeout for 1 clock.
  - Read timeout loads 0xFFFFFFFF as response data. Write timeout goes straight to IDLE.
  - An ack arriving on the same edge as the timeout is treated as success; no err_timeout.
- RESP:
  - out_valid=1 with out_data = shift[31:24].
  - On each out_valid & out_ready, shift left 8 bits. After the 4th transfer, out_valid=0 and state IDLE.
  - out_data is stable while out_valid & !out_ready.
- End-to-end timing: the next frame's opcode can be accepted the cycle after wb_cyc falls (write) or after the 4th response byte (read).
- Back-pressure on in_valid=0 mid-frame: wait indefinitely, no timeout on the input side.

Optional Feature:
WB_BYTE_MASTER_AUTOINC_EN
- Defined:
  - Opcodes 0x11 (write-next: 4 data bytes, no address) and 0x12 (read-next: no further bytes) are valid.
  - Both use the stored address. After every completed or timed-out bus cycle of any opcode, the stored address increments by 1, wrapping 0xFFFF → 0x0000.
- Undefined: 0x11 and 0x12 are ignored like other unknown opcodes, and the address register is not incremented.

Test Plan:
- Write: bytes 01 00 01 00 04 04 04, slave acks 1 cycle after cyc → wb_addr=0x0001, wb_wdata=0x00040404, wb_we=1, wb_cyc high exactly 2 clocks; in_ready=0 during cyc.
- Read: bytes 02 00 00, slave returns 0x12345678 with 3-cycle ack delay → out bytes 12,34,56,78 in order. With out_ready toggling 1/0, each byte is held stable until accepted.
- Timeout: TIMEOUT_CYCLES=8, read 02 00 03, no ack → wb_cyc drops after 8 cycles, err_timeout one pulse, response FF FF FF FF.
- Junk: bytes 7F 00 then a valid write → junk ignored, write executes correctly, no spurious wb_cyc.
- Reset: assert rst while wb_cyc=1 → next edge wb_cyc=0, out_valid=0, in_ready=0 during rst, 1 after release. A following write frame works.
- AUTOINC (macro defined): 01 FF FF 00 00 00 AA then 11 00 00 00 BB → writes 0x000000AA to 0xFFFF, then 0x000000BB to 0x0000.
